dmem_portb_arbiter: RTL and testbench

- Shares the B port of the four-bank data memory (general, matrix_a, matrix_b, output_matrix) between two requesters: requester 0 (PS/AXI slave) and requester 1 (matrix-multiply engine).
- Performs round-robin arbitration with optional bounded burst locking, drives the memory B-port controls, and routes the 1-cycle-latency read data from the addressed bank back to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 28 ++
 rtl/dmem_portb_arbiter_rr_grant2.sv | 44 ++++
 rtl/dmem_portb_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_portb_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory B-port arbiter.
//   arb_state_t : arbiter FSM state (free-for-all IDLE vs. burst-locked OWN)
//   REQ_*       : requester indices (PS/AXI slave, matrix-multiply engine)
//   BANK_*      : bank index carried in the top two byte-address bits
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam logic REQ_PS  = 1'b0;
  localparam logic REQ_MMM = 1'b1;

  localparam logic [1:0] BANK_GEN = 2'd0;
  localparam logic [1:0] BANK_A   = 2'd1;
  localparam logic [1:0] BANK_B   = 2'd2;
  localparam logic [1:0] BANK_OUT = 2'd3;

  // Requester index -> one-hot 2-bit vector.
  function automatic logic [1:0] req_onehot(input logic idx);
    return (idx == REQ_MMM) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_portb_arbiter_rr_grant2.sv
// -----------------------------------------------------------------------------
// rr_grant2
// Combinational two-way round-robin grant.
//   i_valid  : per-requester request valid
//   i_rr_ptr : requester favoured when both are valid in IDLE
//   i_state  : arbiter state; in OWN only the owner may be granted
//   i_owner  : current lock owner
//   o_grant  : one-hot or zero grant vector
// -----------------------------------------------------------------------------
module rr_grant2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] i_valid,
  input  logic       i_rr_ptr,
  input  arb_state_t i_state,
  input  logic       i_owner,
  output logic [1:0] o_grant
);

  // Grant selection: free choice in IDLE, owner-only while locked.
  always_comb begin
    o_grant = 2'b00;
    case (i_state)
      ARB_IDLE: begin
        case (i_valid)
          2'b01:   o_grant = 2'b01;
          2'b10:   o_grant = 2'b10;
          2'b11:   o_grant = req_onehot(i_rr_ptr);
          default: o_grant = 2'b00;
        endcase
      end
      ARB_OWN: begin
        // The other requester is held off even when valid.
        if (i_valid[i_owner]) begin
          o_grant = req_onehot(i_owner);
        end else begin
          o_grant = 2'b00;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_portb_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_portb_arbiter
// Shares the B port of the four-bank data memory between requester 0 (PS/AXI
// slave) and requester 1 (matrix-multiply engine). Round-robin arbitration
// with optional bounded burst locking; routes the 1-cycle-latency bank read
// data back to the requester that issued the read.
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/ready/lock [1:0] per-requester handshake and lock request
//   req_addr*/wdata*/be*       per-requester byte address, data, byte enables
//                              (be == 0 means read)
//   rsp_valid [1:0], rsp_data  read response, one cycle after the accept
//   dmem_byte_addr/data_in/byte_wr_en  memory B-port drive
//   dmem0..3_data_out          per-bank B-port read data
//   owner, locked              current/last grantee, FSM in OWN
// -----------------------------------------------------------------------------
module dmem_portb_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 256,
  parameter int NUM_COL   = 4,
  parameter int MAX_BURST = 16,
  localparam int ADDR_W   = $clog2(SIZE) + 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [1:0]         req_lock,
  input  logic [ADDR_W-1:0]  req_addr0,
  input  logic [ADDR_W-1:0]  req_addr1,
  input  logic [WIDTH-1:0]   req_wdata0,
  input  logic [WIDTH-1:0]   req_wdata1,
  input  logic [NUM_COL-1:0] req_be0,
  input  logic [NUM_COL-1:0] req_be1,
  output logic [1:0]         rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [ADDR_W-1:0]  dmem_byte_addr,
  output logic [WIDTH-1:0]   dmem_data_in,
  output logic [NUM_COL-1:0] dmem_byte_wr_en,
  input  logic [WIDTH-1:0]   dmem0_data_out,
  input  logic [WIDTH-1:0]   dmem1_data_out,
  input  logic [WIDTH-1:0]   dmem2_data_out,
  input  logic [WIDTH-1:0]   dmem3_data_out,
  output logic               owner,
  output logic               locked
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W:0] BURST_LIMIT = (CNT_W + 1)'(MAX_BURST);
  localparam logic [CNT_W-1:0] BURST_ONE = CNT_W'(1);

  arb_state_t         r_state,     w_state_nxt;
  logic               r_owner,     w_owner_nxt;
  logic               r_rr_ptr,    w_rr_ptr_nxt;
  logic [CNT_W-1:0]   r_burst_cnt, w_burst_cnt_nxt;
  logic               r_rd_pend,   w_rd_pend_nxt;
  logic               r_rd_who,    w_rd_who_nxt;
  logic [1:0]         r_rd_bank,   w_rd_bank_nxt;

  logic [1:0]         w_grant;
  logic [1:0]         w_ready;
  logic [1:0]         w_acc;
  logic               w_any_acc;
  logic               w_acc_id;
  logic               w_acc_read;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [WIDTH-1:0]   w_sel_wdata;
  logic [NUM_COL-1:0] w_sel_be;
  logic [CNT_W:0]     w_burst_inc;

  rr_grant2 u_grant (
    .i_valid  (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .i_state  (r_state),
    .i_owner  (r_owner),
    .o_grant  (w_grant)
  );

  // While reset is asserted nothing may be accepted, even with valid inputs.
  assign w_ready   = w_grant & {2{reset_n}};
  assign req_ready = w_ready;
  assign w_acc     = req_valid & w_ready;
  assign w_any_acc = |w_acc;
  assign w_acc_id  = w_acc[1];

  // Select the accepted requester's beat onto the memory port; zeros when idle.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    if (w_acc[0]) begin
      w_sel_addr  = req_addr0;
      w_sel_wdata = req_wdata0;
      w_sel_be    = req_be0;
    end else if (w_acc[1]) begin
      w_sel_addr  = req_addr1;
      w_sel_wdata = req_wdata1;
      w_sel_be    = req_be1;
    end else begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_be    = '0;
    end
  end

  assign dmem_byte_addr  = w_sel_addr;
  assign dmem_data_in    = w_sel_wdata;
  assign dmem_byte_wr_en = w_sel_be;
  assign w_acc_read      = w_any_acc & (w_sel_be == '0);
  assign w_burst_inc     = {1'b0, r_burst_cnt} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state logic for the lock FSM, round-robin pointer and read tracker.
  always_comb begin
    w_state_nxt     = r_state;
    w_owner_nxt     = r_owner;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_burst_cnt_nxt = r_burst_cnt;
    w_rd_pend_nxt   = w_acc_read;
    w_rd_who_nxt    = r_rd_who;
    w_rd_bank_nxt   = r_rd_bank;

    if (w_acc_read) begin
      w_rd_who_nxt  = w_acc_id;
      w_rd_bank_nxt = w_sel_addr[ADDR_W-1:ADDR_W-2];
    end else begin
      w_rd_who_nxt  = r_rd_who;
      w_rd_bank_nxt = r_rd_bank;
    end

    case (r_state)
      ARB_IDLE: begin
        if (w_any_acc) begin
          w_owner_nxt  = w_acc_id;
          w_rr_ptr_nxt = ~w_acc_id;
          if (req_lock[w_acc_id]) begin
            w_state_nxt     = ARB_OWN;
            w_burst_cnt_nxt = BURST_ONE;
          end else begin
            w_state_nxt     = ARB_IDLE;
            w_burst_cnt_nxt = '0;
          end
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_OWN: begin
        if (w_any_acc) begin
          // Only the owner can be accepted here; release on unlock or limit.
          if (req_lock[r_owner] && (w_burst_inc < BURST_LIMIT)) begin
            w_state_nxt     = ARB_OWN;
            w_burst_cnt_nxt = w_burst_inc[CNT_W-1:0];
          end else begin
            w_state_nxt     = ARB_IDLE;
            w_rr_ptr_nxt    = ~r_owner;
            w_burst_cnt_nxt = '0;
          end
        end else if (!req_valid[r_owner]) begin
          w_state_nxt     = ARB_IDLE;
          w_rr_ptr_nxt    = ~r_owner;
          w_burst_cnt_nxt = '0;
        end else begin
          w_state_nxt = ARB_OWN;
        end
      end
      default: begin
        w_state_nxt     = ARB_IDLE;
        w_burst_cnt_nxt = '0;
      end
    endcase
  end

  // State registers; reset also drops any in-flight read response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ARB_IDLE;
      r_owner     <= REQ_PS;
      r_rr_ptr    <= REQ_PS;
      r_burst_cnt <= '0;
      r_rd_pend   <= 1'b0;
      r_rd_who    <= REQ_PS;
      r_rd_bank   <= BANK_GEN;
    end else begin
      r_state     <= w_state_nxt;
      r_owner     <= w_owner_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_rd_pend   <= w_rd_pend_nxt;
      r_rd_who    <= w_rd_who_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
    end
  end

  // Route the addressed bank's read data to the requester that issued it.
  always_comb begin
    rsp_valid = 2'b00;
    rsp_data  = '0;
    if (r_rd_pend) begin
      rsp_valid = req_onehot(r_rd_who);
      case (r_rd_bank)
        BANK_GEN: rsp_data = dmem0_data_out;
        BANK_A:   rsp_data = dmem1_data_out;
        BANK_B:   rsp_data = dmem2_data_out;
        BANK_OUT: rsp_data = dmem3_data_out;
        default:  rsp_data = '0;
      endcase
    end else begin
      rsp_valid = 2'b00;
      rsp_data  = '0;
    end
  end

  assign owner  = r_owner;
  assign locked = (r_state == ARB_OWN);

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_portb_arbiter
// Directed bench for dmem_portb_arbiter with a behavioural four-bank memory
// (1-cycle registered read) and a reference word array. Expected read
// responses are queued when a read is accepted and popped the next cycle.
// -----------------------------------------------------------------------------
module tb_dmem_portb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_lock, rsp_valid;
  logic [9:0]  req_addr0, req_addr1, dmem_byte_addr;
  logic [31:0] req_wdata0, req_wdata1, rsp_data, dmem_data_in;
  logic [3:0]  req_be0, req_be1, dmem_byte_wr_en;
  logic        owner, locked;

  logic [31:0] mem  [4][64];
  logic [31:0] refm [4][64];
  logic [31:0] dout [4];
  logic        mem_init_done = 1'b0;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  always #5 clk = ~clk;

  dmem_portb_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_lock        (req_lock),
    .req_addr0       (req_addr0),
    .req_addr1       (req_addr1),
    .req_wdata0      (req_wdata0),
    .req_wdata1      (req_wdata1),
    .req_be0         (req_be0),
    .req_be1         (req_be1),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .dmem_byte_addr  (dmem_byte_addr),
    .dmem_data_in    (dmem_data_in),
    .dmem_byte_wr_en (dmem_byte_wr_en),
    .dmem0_data_out  (dout[0]),
    .dmem1_data_out  (dout[1]),
    .dmem2_data_out  (dout[2]),
    .dmem3_data_out  (dout[3]),
    .owner           (owner),
    .locked          (locked)
  );

  function automatic logic [31:0] init_word(input int b, input int w);
    if (b == 1 && w == 1) return 32'hDEADBEEF;
    return 32'(b * 32'h0100_0000 + w * 32'h0001_0001 + 32'h0000_5A00);
  endfunction

  // Behavioural memory: preload once, byte-lane writes, registered read.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int b = 0; b < 4; b++)
        for (int w = 0; w < 64; w++)
          mem[b][w] <= init_word(b, w);
      mem_init_done <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (dmem_byte_addr[9:8] == 2'(b))
          for (int c = 0; c < 4; c++)
            if (dmem_byte_wr_en[c])
              mem[b][dmem_byte_addr[7:2]][8*c +: 8] <= dmem_data_in[8*c +: 8];
    end
    for (int b = 0; b < 4; b++)
      dout[b] <= mem[b][dmem_byte_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check the response of the previous
  // cycle, the grant, lock state and memory drive, then update the scoreboard.
  task automatic cycle(input logic [1:0] v, input logic [1:0] l,
                       input logic [9:0] x0, input logic [31:0] d0, input logic [3:0] b0,
                       input logic [9:0] x1, input logic [31:0] d1, input logic [3:0] b1,
                       input logic [1:0] er, input logic el, input string tag);
    logic [1:0]  acc;
    logic [9:0]  ea;
    logic [31:0] ed;
    logic [3:0]  eb;
    exp_t        it;
    @(negedge clk);
    req_valid = v;  req_lock = l;
    req_addr0 = x0; req_wdata0 = d0; req_be0 = b0;
    req_addr1 = x1; req_wdata1 = d1; req_be1 = b1;
    #1;
    if (sb.size() > 0) begin
      it = sb.pop_front();
      chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'(it.vld));
      chk({tag, ".rsp_data"}, rsp_data, it.data);
    end else begin
      chk({tag, ".rsp_valid_idle"}, 32'(rsp_valid), 32'h0);
      chk({tag, ".rsp_data_idle"}, rsp_data, 32'h0);
    end
    chk({tag, ".ready"}, 32'(req_ready), 32'(er));
    chk({tag, ".locked"}, 32'(locked), 32'(el));
    acc = v & er;
    ea = 10'h000; ed = 32'h0; eb = 4'h0;
    if (acc[0]) begin ea = x0; ed = d0; eb = b0; end
    else if (acc[1]) begin ea = x1; ed = d1; eb = b1; end
    chk({tag, ".addr"}, 32'(dmem_byte_addr), 32'(ea));
    chk({tag, ".wdata"}, dmem_data_in, ed);
    chk({tag, ".wr_en"}, 32'(dmem_byte_wr_en), 32'(eb));
    if (acc != 2'b00) begin
      if (eb == 4'h0) begin
        it.vld  = acc;
        it.data = refm[ea[9:8]][ea[7:2]];
        sb.push_back(it);
      end else begin
        for (int c = 0; c < 4; c++)
          if (eb[c]) refm[ea[9:8]][ea[7:2]][8*c +: 8] = ed[8*c +: 8];
      end
    end
  endtask

  task automatic idle(input logic el, input string tag);
    cycle(2'b00, 2'b00, 10'h0, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0, 2'b00, el, tag);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    req_valid = 2'b00; req_lock = 2'b00;
    reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < 4; b++)
      for (int w = 0; w < 64; w++)
        refm[b][w] = init_word(b, w);
    reset_n = 1'b0;
    req_valid = 2'b11; req_lock = 2'b11;
    req_addr0 = 10'h104; req_addr1 = 10'h200;
    req_wdata0 = 32'h1111_1111; req_wdata1 = 32'h2222_2222;
    req_be0 = 4'hF; req_be1 = 4'hF;

    // Reset state, with requests held valid to show nothing is accepted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst.ready", 32'(req_ready), 32'h0);
    chk("rst.wr_en", 32'(dmem_byte_wr_en), 32'h0);
    chk("rst.addr", 32'(dmem_byte_addr), 32'h0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst.locked", 32'(locked), 32'h0);
    chk("rst.owner", 32'(owner), 32'h0);
    req_valid = 2'b00; req_lock = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;

    // Single read by req0 from 0x104 (bank 1, word 1 = 0xDEADBEEF).
    cycle(2'b01, 2'b00, 10'h104, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0, 2'b01, 1'b0, "single_rd");
    idle(1'b0, "single_rsp");

    // Contention from reset: grants alternate 0,1,0,1.
    pulse_reset();
    for (int k = 0; k < 4; k++)
      cycle(2'b11, 2'b00, 10'(10'h008 + 4*k), 32'h0, 4'h0, 10'(10'h200 + 4*k), 32'h0, 4'h0,
            (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, $sformatf("contend%0d", k));
    idle(1'b0, "contend_drain");

    // Full write by req0 then read of the same address by req1.
    cycle(2'b01, 2'b00, 10'h300, 32'hA5A5A5A5, 4'hF, 10'h0, 32'h0, 4'h0, 2'b01, 1'b0, "wr_full");
    cycle(2'b10, 2'b00, 10'h0, 32'h0, 4'h0, 10'h300, 32'h0, 4'h0, 2'b10, 1'b0, "rd_after_wr");

    // Partial write by req1 to bank 1, then read back by req0.
    cycle(2'b10, 2'b00, 10'h0, 32'h0, 4'h0, 10'h140, 32'h00CC0000, 4'b0100, 2'b10, 1'b0, "wr_part");
    idle(1'b0, "wr_part_after");
    cycle(2'b01, 2'b00, 10'h140, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0, 2'b01, 1'b0, "rd_part");

    // Burst lock: req1 holds 16 beats, then req0 wins one, then req1 resumes.
    cycle(2'b10, 2'b10, 10'h010, 32'h0, 4'h0, 10'h280, 32'h0, 4'h0, 2'b10, 1'b0, "burst1");
    for (int k = 2; k <= 16; k++)
      cycle(2'b11, 2'b10, 10'h010, 32'h0, 4'h0, 10'(10'h280 + 4*k), 32'h0, 4'h0, 2'b10, 1'b1,
            $sformatf("burst%0d", k));
    cycle(2'b11, 2'b10, 10'h010, 32'h0, 4'h0, 10'h2C4, 32'h0, 4'h0, 2'b01, 1'b0, "burst17");
    cycle(2'b11, 2'b10, 10'h014, 32'h0, 4'h0, 10'h2C8, 32'h0, 4'h0, 2'b10, 1'b0, "burst18");
    cycle(2'b11, 2'b10, 10'h014, 32'h0, 4'h0, 10'h2CC, 32'h0, 4'h0, 2'b10, 1'b1, "burst19");
    idle(1'b1, "burst_drop");
    idle(1'b0, "burst_idle");
    chk("burst.owner", 32'(owner), 32'h1);

    // Reset during beat 5 of a locked req1 burst with a read pending.
    cycle(2'b10, 2'b10, 10'h0, 32'h0, 4'h0, 10'h0C0, 32'h0, 4'h0, 2'b10, 1'b0, "rstb1");
    cycle(2'b10, 2'b10, 10'h0, 32'h0, 4'h0, 10'h0C4, 32'h0, 4'h0, 2'b10, 1'b1, "rstb2");
    cycle(2'b10, 2'b10, 10'h0, 32'h0, 4'h0, 10'h0C8, 32'h0, 4'h0, 2'b10, 1'b1, "rstb3");
    cycle(2'b10, 2'b10, 10'h0, 32'h0, 4'h0, 10'h0CC, 32'h77665544, 4'hF, 2'b10, 1'b1, "rstb4");
    cycle(2'b10, 2'b10, 10'h0, 32'h0, 4'h0, 10'h0CC, 32'h0, 4'h0, 2'b10, 1'b1, "rstb5");
    @(posedge clk);
    #1;
    chk("rstb.locked_pre", 32'(locked), 32'h1);
    chk("rstb.rsp_pre", 32'(rsp_valid), 32'h2);
    req_be1 = 4'hF;
    #1;
    chk("rstb.wr_en_pre", 32'(dmem_byte_wr_en), 32'hF);
    reset_n = 1'b0;
    #1;
    chk("rstb.locked", 32'(locked), 32'h0);
    chk("rstb.rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rstb.rsp_data", rsp_data, 32'h0);
    chk("rstb.wr_en", 32'(dmem_byte_wr_en), 32'h0);
    chk("rstb.ready", 32'(req_ready), 32'h0);
    sb.delete();
    @(negedge clk);
    req_valid = 2'b00; req_lock = 2'b00; req_be1 = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;
    cycle(2'b01, 2'b00, 10'h0CC, 32'h0, 4'h0, 10'h0, 32'h0, 4'h0, 2'b01, 1'b0, "post_rst");
    idle(1'b0, "post_rst_rsp");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
